// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Each slot opens with a blank window, then lights one enabled digit. Disabled digits are skipped.
module digit_scan_ctrl #(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] digit_en,
   output logic [1:0] sel,
   output logic [3:0] an,
   output logic       digit_tick,
   output logic       frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t          state_q, state_d, start_state;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [3:0]      an_q, an_d;
   logic            digit_tick_q, digit_tick_d;
   logic            frame_tick_q, frame_tick_d;
   logic [1:0]      first_sel, next_sel;
   logic            found;

   assign start_state = HAS_BLANK ? BLANK : SHOW;

   // Lowest enabled digit on (re)start; rotating search from sel+1 on slot advance.
   always_comb begin
      first_sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (digit_en[i]) first_sel = 2'(i);
      end
      next_sel = sel_q;
      found    = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && digit_en[sel_q + 2'(k)]) begin
            next_sel = sel_q + 2'(k);
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      digit_tick_d = 1'b0;
      frame_tick_d = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = start_state;
               cnt_d   = '0;
               sel_d   = first_sel;
            end
            default: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d      = start_state;
                  cnt_d        = '0;
                  sel_d        = next_sel;
                  digit_tick_d = 1'b1;
                  frame_tick_d = (next_sel <= sel_q);
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (state_q == BLANK && cnt_q == BLANK_LAST) state_d = SHOW;
               end
            end
         endcase
      end
      // Anode follows the next state so it can never be lit during BLANK.
      an_d = (state_d == SHOW && digit_en[sel_d]) ? ~(4'b0001 << sel_d) : 4'b1111;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sel_q        <= 2'd0;
         an_q         <= 4'b1111;
         digit_tick_q <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         an_q         <= an_d;
         digit_tick_q <= digit_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign sel        = sel_q;
   assign an         = an_q;
   assign digit_tick = digit_tick_q;
   assign frame_tick = frame_tick_q;

endmodule
